// File: rtl/iomem_led_pwm_pkg.sv
// Shared definitions for the iomem PWM LED controller: register offsets,
// field widths and a byte-strobe merge helper.
package iomem_led_pwm_pkg;

  localparam int PHASE_W = 8;
  localparam int PRESC_W = 8;

  localparam logic [7:0] CTRL    = 8'h00;
  localparam logic [7:0] MODE    = 8'h04;
  localparam logic [7:0] STATIC  = 8'h08;
  localparam logic [7:0] BREATHE = 8'h0C;
  localparam logic [7:0] DUTY0   = 8'h10;
  localparam logic [7:0] STATUS  = 8'h30;

  // Keep the old byte unless its strobe is set
  function automatic logic [7:0] merge_byte(input logic [7:0] old_val,
                                            input logic [7:0] new_val,
                                            input logic       strobe);
    return strobe ? new_val : old_val;
  endfunction

endpackage

// File: rtl/iomem_led_pwm_timebase.sv
// PWM timebase: a prescaler feeding an 8-bit phase counter.
// Both counters are held at zero while disabled.
module led_pwm_timebase
  import iomem_led_pwm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PHASE_W-1:0] phase,
  output logic               tick,
  output logic               wrap
);

  logic [PRESC_W-1:0] pre_cnt;

  // >= rather than == so a prescale lowered below the current count still ticks
  assign tick = en & (pre_cnt >= prescale);
  assign wrap = tick & (phase == '1);

  // Prescaler and phase counter; both restart from zero whenever disabled
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      phase   <= phase + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iomem_led_pwm.sv
// Memory-mapped PWM LED controller on the picosoc iomem bus.
// Each channel is a static level or an 8-bit PWM whose duty is double
// buffered and swapped on the phase wrap, so duty updates never glitch.
// Optional feature: define IOMEM_LED_PWM_BREATHE_EN to build the triangle
// "breathing" level generator and the BREATHE register.
module iomem_led_pwm
  import iomem_led_pwm_pkg::*;
#(
  parameter int          NCH       = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           iomem_valid,
  output logic           iomem_ready,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic [NCH-1:0] led_out
);

  logic               sel;
  logic               wr;
  logic [7:0]         reg_ofs;
  logic [31:0]        rd_data;
  logic               en;
  logic [PRESC_W-1:0] prescale;
  logic [NCH-1:0]     mode_reg;
  logic [NCH-1:0]     static_reg;
  logic [PHASE_W-1:0] duty_pend [NCH];
  logic [PHASE_W-1:0] duty_shad [NCH];
  logic [PHASE_W-1:0] cmp_val   [NCH];
  logic [PHASE_W-1:0] phase;
  logic               tick;
  logic               wrap;
  logic               unused_bits;

`ifdef IOMEM_LED_PWM_BREATHE_EN
  logic [NCH-1:0]     breathe_reg;
  logic [PHASE_W-1:0] level;
  logic               level_up;
`endif

  assign sel     = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_ADDR[31:24]);
  assign wr      = sel & (|iomem_wstrb);
  assign reg_ofs = {iomem_addr[7:2], 2'b00};

  assign unused_bits = &{1'b0, iomem_addr[23:8], iomem_addr[1:0], iomem_wdata[31:16], tick};

  led_pwm_timebase u_timebase (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .prescale (prescale),
    .phase    (phase),
    .tick     (tick),
    .wrap     (wrap)
  );

  // Register file writes, byte strobes honoured individually
  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      prescale   <= '0;
      mode_reg   <= '0;
      static_reg <= '0;
`ifdef IOMEM_LED_PWM_BREATHE_EN
      breathe_reg <= '0;
`endif
      for (int i = 0; i < NCH; i++) duty_pend[i] <= '0;
    end else if (wr) begin
      case (reg_ofs)
        CTRL: begin
          if (iomem_wstrb[0]) en <= iomem_wdata[0];
          prescale <= merge_byte(prescale, iomem_wdata[15:8], iomem_wstrb[1]);
        end
        MODE:    if (iomem_wstrb[0]) mode_reg   <= iomem_wdata[NCH-1:0];
        STATIC:  if (iomem_wstrb[0]) static_reg <= iomem_wdata[NCH-1:0];
`ifdef IOMEM_LED_PWM_BREATHE_EN
        BREATHE: if (iomem_wstrb[0]) breathe_reg <= iomem_wdata[NCH-1:0];
`endif
        default: ;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (reg_ofs == DUTY0 + 8'(4 * i))
          duty_pend[i] <= merge_byte(duty_pend[i], iomem_wdata[7:0], iomem_wstrb[0]);
      end
    end
  end

  // Shadow duties follow the pending values on wrap, or continuously while stopped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) duty_shad[i] <= '0;
    end else if (!en || wrap) begin
      for (int i = 0; i < NCH; i++) duty_shad[i] <= duty_pend[i];
    end
  end

`ifdef IOMEM_LED_PWM_BREATHE_EN
  // Triangle level 0..255..0 stepping once per PWM period; parked at 0 while stopped
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      level    <= '0;
      level_up <= 1'b1;
    end else if (wrap) begin
      if (level_up) begin
        if (level == '1) begin
          level_up <= 1'b0;
          level    <= level - 1'b1;
        end else begin
          level <= level + 1'b1;
        end
      end else begin
        if (level == '0) begin
          level_up <= 1'b1;
          level    <= level + 1'b1;
        end else begin
          level <= level - 1'b1;
        end
      end
    end
  end
`endif

  // Per-channel compare value: shadow duty, or the breathing level when selected
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cmp_val[i] = duty_shad[i];
`ifdef IOMEM_LED_PWM_BREATHE_EN
      if (breathe_reg[i]) cmp_val[i] = level;
`endif
    end
  end

  // Read mux; unmapped offsets and unused bits read as zero
  always_comb begin
    rd_data = '0;
    case (reg_ofs)
      CTRL:    rd_data = {16'b0, prescale, 7'b0, en};
      MODE:    rd_data[NCH-1:0] = mode_reg;
      STATIC:  rd_data[NCH-1:0] = static_reg;
`ifdef IOMEM_LED_PWM_BREATHE_EN
      BREATHE: rd_data[NCH-1:0] = breathe_reg;
`endif
      STATUS:  rd_data[PHASE_W-1:0] = phase;
      default: ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (reg_ofs == DUTY0 + 8'(4 * i)) rd_data = {24'b0, duty_pend[i]};
    end
  end

  // Single-cycle bus acknowledge with registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd_data : '0;
    end
  end

  // Registered LED drive; PWM channels are forced off while the timebase is stopped
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        led_out[i] <= mode_reg[i] ? (en & (phase < cmp_val[i])) : static_reg[i];
    end
  end

endmodule

// File: tb/tb_iomem_led_pwm.sv
// Directed self-checking bench for iomem_led_pwm (default NCH=8).
// Honours IOMEM_LED_PWM_BREATHE_EN to pick breathing or plain expectations.
module tb_iomem_led_pwm;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  led_out;

  int errors = 0;
  int checks = 0;

  iomem_led_pwm #(.NCH(8), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One bus access; returns once ready is seen (bounded)
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!iomem_ready && n < 8);
    if (!iomem_ready) checkOutput("bus_timeout", {31'b0, iomem_ready}, 32'd1);
    rdata = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
  endtask

  task automatic writeReg(input logic [7:0] ofs, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(BASE | 32'(ofs), 4'hF, data, dummy);
  endtask

  task automatic readReg(input logic [7:0] ofs, output logic [31:0] data);
    applyStimulus(BASE | 32'(ofs), 4'h0, 32'hDEAD_BEEF, data);
  endtask

  // Counts high samples of one channel over n cycles, starting with the current sample
  task automatic countHigh(input int ch, input int n, output int cnt);
    cnt = int'(led_out[ch]);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      cnt += int'(led_out[ch]);
    end
  endtask

  // Advances to the first sample where the channel goes 0 -> 1 (bounded)
  task automatic waitRise(input int ch, input int limit, input string tag);
    logic prev;
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      prev = led_out[ch];
      @(posedge clk); #1;
      if (led_out[ch] && !prev) ok = 1'b1;
    end
    if (!ok) checkOutput(tag, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd, s1, s2;
    int          cnt, cnt2;
    int          rcnt;

    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    reset       = 1'b1;

    // Request launched while reset is held must not be acknowledged
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE;
    @(posedge clk); #1;
    checkOutput("ready_in_reset", {31'b0, iomem_ready}, 32'd0);
    @(negedge clk);
    iomem_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state: all registers read 0, one-cycle ready, LEDs off
    checkOutput("led_reset", {24'b0, led_out}, 32'd0);
    for (int a = 0; a <= 8'h30; a += 4) begin
      readReg(8'(a), rd);
      checkOutput($sformatf("reset_read_%02h", a), rd, 32'd0);
      @(posedge clk); #1;
      checkOutput("ready_pulse", {31'b0, iomem_ready}, 32'd0);
      checkOutput("rdata_idle", iomem_rdata, 32'd0);
    end

    // Foreign address: no acknowledge
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    rcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      rcnt += int'(iomem_ready);
    end
    iomem_valid = 1'b0;
    checkOutput("foreign_addr", 32'(rcnt), 32'd0);

    // Byte strobes, unmapped offset, unused bits, DUTY readback
    applyStimulus(BASE, 4'b0010, 32'hFFFF_05FF, rd);
    readReg(CTRL_OFS(), rd);
    checkOutput("ctrl_byte1_only", rd, 32'h0000_0500);
    writeReg(8'h34, 32'hFFFF_FFFF);
    readReg(8'h34, rd);
    checkOutput("unmapped_read", rd, 32'd0);
    writeReg(8'h04, 32'hFFFF_FFFF);
    readReg(8'h04, rd);
    checkOutput("mode_unused_bits", rd, 32'h0000_00FF);
    writeReg(8'h2C, 32'h1234_56AB);
    readReg(8'h2C, rd);
    checkOutput("duty7_readback", rd, 32'h0000_00AB);
    writeReg(8'h00, 32'd0);

    // Basic PWM: duty 64 of 256, STATUS advances once per clock
    writeReg(8'h04, 32'h01);
    writeReg(8'h10, 32'd64);
    writeReg(8'h00, 32'h0000_0001);
    repeat (10) @(posedge clk);
    #1;
    countHigh(0, 256, cnt);
    checkOutput("duty64_high", 32'(cnt), 32'd64);
    readReg(8'h30, s1);
    readReg(8'h30, s2);
    checkOutput("status_step", {24'b0, 8'(s2[7:0] - s1[7:0])}, 32'd2);

    // Prescale 3: period 1024, high 256
    writeReg(8'h00, 32'h0000_0301);
    repeat (8) @(posedge clk);
    #1;
    countHigh(0, 1024, cnt);
    checkOutput("presc3_high", 32'(cnt), 32'd256);
    applyStimulus(BASE, 4'b0001, 32'd0, rd);
    readReg(8'h00, rd);
    checkOutput("en_cleared", rd, 32'h0000_0300);
    readReg(8'h30, rd);
    checkOutput("phase_stopped", rd, 32'd0);
    @(posedge clk); #1;
    checkOutput("pwm_off_disabled", {31'b0, led_out[0]}, 32'd0);

    // Duty change mid-period waits for the wrap
    writeReg(8'h00, 32'h0000_0001);
    repeat (98) @(posedge clk);
    writeReg(8'h10, 32'd200);
    countHigh(0, 100, cnt);
    checkOutput("old_duty_held", 32'(cnt), 32'd0);
    waitRise(0, 300, "rise_a");
    countHigh(0, 256, cnt);
    checkOutput("duty200_high", 32'(cnt), 32'd200);

    // Write landing on the wrap edge applies one period later
    waitRise(0, 300, "rise_b");
    repeat (254) @(posedge clk);
    writeReg(8'h10, 32'd30);
    waitRise(0, 300, "rise_c");
    countHigh(0, 256, cnt);
    checkOutput("wrap_write_old", 32'(cnt), 32'd200);
    waitRise(0, 300, "rise_d");
    countHigh(0, 256, cnt);
    checkOutput("wrap_write_new", 32'(cnt), 32'd30);

    // Static outputs, independent of EN
    writeReg(8'h00, 32'd0);
    writeReg(8'h04, 32'd0);
    writeReg(8'h08, 32'h0000_00A5);
    @(posedge clk); #1;
    checkOutput("static_a5", {24'b0, led_out}, 32'h0000_00A5);
    writeReg(8'h00, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("static_a5_en", {24'b0, led_out}, 32'h0000_00A5);

    // Breathing on channel 1 (or plain DUTY1 without the feature)
    writeReg(8'h00, 32'd0);
    writeReg(8'h08, 32'd0);
    writeReg(8'h14, 32'd10);
    writeReg(8'h0C, 32'h02);
    readReg(8'h0C, rd);
`ifdef IOMEM_LED_PWM_BREATHE_EN
    checkOutput("breathe_readback", rd, 32'h02);
`else
    checkOutput("breathe_readback", rd, 32'h00);
`endif
    writeReg(8'h04, 32'h02);
    writeReg(8'h00, 32'd1);
    waitRise(1, 700, "rise_br1");
    countHigh(1, 256, cnt);
    waitRise(1, 300, "rise_br2");
    countHigh(1, 256, cnt2);
`ifdef IOMEM_LED_PWM_BREATHE_EN
    checkOutput("breathe_p1", 32'(cnt), 32'd1);
    checkOutput("breathe_p2", 32'(cnt2), 32'd2);
`else
    checkOutput("duty1_p1", 32'(cnt), 32'd10);
    checkOutput("duty1_p2", 32'(cnt2), 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [7:0] CTRL_OFS();
    return 8'h00;
  endfunction

endmodule
